// File: rtl/spongent_padder_if.sv
// Byte-stream input and hash absorb handshake between a message source,
// spongent_padder and spongent_hash.
interface spongent_padder_if #(
  parameter int RATE        = 8,
  parameter int COUNT_WIDTH = 16
);
  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic [RATE-1:0]        hash_in;
  logic                   hash_in_valid;
  logic                   hash_in_received;
  logic                   hash_in_completed;
  logic [COUNT_WIDTH-1:0] block_count;

  // Environment side: produces bytes and acknowledges blocks.
  modport master (
    output s_data, s_valid, s_last, hash_in_received,
    input  s_ready, hash_in, hash_in_valid, hash_in_completed, block_count
  );

  // Padder side.
  modport slave (
    input  s_data, s_valid, s_last, hash_in_received,
    output s_ready, hash_in, hash_in_valid, hash_in_completed, block_count
  );
endinterface

// File: rtl/spongent_padder.sv
// Packs a byte stream MSB-first into RATE-bit blocks, appends Spongent
// padding (0x80 then zeros) and drives the hash absorb handshake.
module spongent_padder #(
  parameter int RATE        = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  spongent_padder_if.slave  bus
);

  localparam int BYTES = RATE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [RATE-1:0]        blk_q, blk_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pad_pending_q, pad_pending_d;
  logic                   last_blk_q, last_blk_d;
  logic [COUNT_WIDTH-1:0] block_count_q, block_count_d;
  logic                   last_slot;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign last_slot = (int'(cnt_q) == BYTES - 1);

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    cnt_d         = cnt_q;
    pad_pending_d = pad_pending_q;
    last_blk_d    = last_blk_q;
    block_count_d = block_count_q;

    case (state_q)
      ST_COLLECT: begin
        if (bus.s_valid) begin
          // A final byte short of the boundary gets its padding in the same edge.
          for (int i = 0; i < BYTES; i++) begin
            if (i == int'(cnt_q)) begin
              blk_d[RATE-1-8*i -: 8] = bus.s_data;
            end else if (bus.s_last && (i > int'(cnt_q))) begin
              blk_d[RATE-1-8*i -: 8] = (i == int'(cnt_q) + 1) ? 8'h80 : 8'h00;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.s_last) begin
            state_d = ST_SEND;
            if (last_slot) begin
              pad_pending_d = 1'b1;
              last_blk_d    = 1'b0;
            end else begin
              last_blk_d    = 1'b1;
            end
          end else if (last_slot) begin
            state_d    = ST_SEND;
            last_blk_d = 1'b0;
          end
        end
      end

      ST_SEND: begin
        if (bus.hash_in_received) begin
          block_count_d = sat_inc(block_count_q);
          state_d       = ST_GAP;
        end
      end

      ST_GAP: begin
        if (last_blk_q) begin
          state_d = ST_DONE;
        end else if (pad_pending_q) begin
          // Message ended exactly on a boundary: emit a block of pure padding.
          blk_d               = '0;
          blk_d[RATE-1 -: 8]  = 8'h80;
          pad_pending_d       = 1'b0;
          last_blk_d          = 1'b1;
          state_d             = ST_SEND;
        end else begin
          // Clearing here keeps unwritten slots at zero while collecting.
          blk_d   = '0;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_COLLECT;
      blk_q         <= '0;
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      last_blk_q    <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      cnt_q         <= cnt_d;
      pad_pending_q <= pad_pending_d;
      last_blk_q    <= last_blk_d;
      block_count_q <= block_count_d;
    end
  end

  assign bus.s_ready           = rst && (state_q == ST_COLLECT);
  assign bus.hash_in           = blk_q;
  assign bus.hash_in_valid     = (state_q == ST_SEND);
  assign bus.hash_in_completed = (state_q == ST_DONE);
  assign bus.block_count       = block_count_q;

endmodule

// File: tb/tb_spongent_padder.sv
// Randomized bench for spongent_padder at RATE 8 and 16, plus a narrow
// block counter to exercise saturation; blocks are compared to a padding model.
module tb_spongent_padder;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         sel = 0;
  logic       drv_valid = 1'b0;
  logic       drv_last  = 1'b0;
  logic       drv_recv  = 1'b0;
  logic [7:0] drv_data  = 8'h00;

  spongent_padder_if #(.RATE(8),  .COUNT_WIDTH(16)) if_a();
  spongent_padder_if #(.RATE(16), .COUNT_WIDTH(16)) if_b();
  spongent_padder_if #(.RATE(8),  .COUNT_WIDTH(3))  if_c();

  spongent_padder #(.RATE(8),  .COUNT_WIDTH(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  spongent_padder #(.RATE(16), .COUNT_WIDTH(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  spongent_padder #(.RATE(8),  .COUNT_WIDTH(3))  dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.s_data = drv_data;
  assign if_a.s_last = drv_last;
  assign if_a.s_valid = drv_valid && (sel == 0);
  assign if_a.hash_in_received = drv_recv && (sel == 0);
  assign if_b.s_data = drv_data;
  assign if_b.s_last = drv_last;
  assign if_b.s_valid = drv_valid && (sel == 1);
  assign if_b.hash_in_received = drv_recv && (sel == 1);
  assign if_c.s_data = drv_data;
  assign if_c.s_last = drv_last;
  assign if_c.s_valid = drv_valid && (sel == 2);
  assign if_c.hash_in_received = drv_recv && (sel == 2);

  logic        o_rdy, o_valid, o_done;
  logic [15:0] o_hin, o_cnt;

  always_comb begin
    o_rdy   = if_a.s_ready;
    o_valid = if_a.hash_in_valid;
    o_done  = if_a.hash_in_completed;
    o_hin   = {8'h00, if_a.hash_in};
    o_cnt   = if_a.block_count;
    if (sel == 1) begin
      o_rdy   = if_b.s_ready;
      o_valid = if_b.hash_in_valid;
      o_done  = if_b.hash_in_completed;
      o_hin   = if_b.hash_in;
      o_cnt   = if_b.block_count;
    end else if (sel == 2) begin
      o_rdy   = if_c.s_ready;
      o_valid = if_c.hash_in_valid;
      o_done  = if_c.hash_in_completed;
      o_hin   = {8'h00, if_c.hash_in};
      o_cnt   = {13'd0, if_c.block_count};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (sel %0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: message ++ 0x80 ++ zeros to a whole number of blocks, cut MSB-first.
  function automatic wq_t ref_blocks(input bq_t m, input int nb);
    bq_t  p = m;
    wq_t  r;
    logic [15:0] v;
    p.push_back(8'h80);
    while ((p.size() % nb) != 0) p.push_back(8'h00);
    for (int b = 0; b < p.size() / nb; b++) begin
      v = '0;
      for (int j = 0; j < nb; j++) v = (v << 8) | 16'(p[b*nb + j]);
      r.push_back(v);
    end
    return r;
  endfunction

  task automatic reset_dut(input int s);
    @(negedge clk);
    sel = s;
    rst = 1'b0;
    drv_valid = 1'b0;
    drv_recv  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", o_rdy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_hash_in", o_hin, 0);
    chk("rst_completed", o_done, 0);
    chk("rst_block_count", o_cnt, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_ready", o_rdy, 1);
  endtask

  // mode 0: random acknowledge; mode 1: hold off the first block for 50 cycles.
  task automatic run_msg(input int s, input bq_t msg, input int mode, input int abort_after);
    wq_t exp, got;
    int  nb   = (s == 1) ? 2 : 1;
    int  maxc = (s == 2) ? 7 : 65535;
    int  idx = 0, in_blk = 0, hold = 0, fin_cyc = -1000;
    logic exp_v = 1'b0, gap = 1'b0, pend = 1'b0, stop = 1'b0, done_seen = 1'b0, dv;
    logic [15:0] held = '0;
    int  want_cnt;
    exp = ref_blocks(msg, nb);
    reset_dut(s);
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      if (stop) break;
      dv        = (idx < msg.size()) && ($urandom_range(0, 3) != 0);
      drv_valid = dv;
      drv_data  = dv ? msg[idx] : 8'($urandom);
      drv_last  = dv ? (idx == msg.size() - 1) : 1'($urandom);
      drv_recv  = (mode == 1) ? (hold >= 50) : 1'($urandom);
      #1;
      if (exp_v) chk("latency_valid", o_valid, 1);
      exp_v = 1'b0;
      if (gap) begin
        chk("gap_valid", o_valid, 0);
        chk("gap_ready", o_rdy, 0);
      end
      if (o_valid) begin
        chk("send_ready", o_rdy, 0);
        if (pend) chk("send_hold", o_hin, held);
        else begin
          held = o_hin;
          pend = 1'b1;
        end
        if (mode == 1 && hold < 50) hold++;
      end
      gap = o_valid && drv_recv;
      if (gap) begin
        got.push_back(o_hin);
        pend = 1'b0;
        if (got.size() == exp.size()) fin_cyc = cyc;
      end
      if (dv && o_rdy) begin
        in_blk++;
        if (in_blk == nb || drv_last) begin
          exp_v  = 1'b1;
          in_blk = 0;
        end
        idx++;
        if (idx == abort_after) stop = 1'b1;
      end
      if (o_done) begin
        done_seen = 1'b1;
        chk("done_timing", cyc - fin_cyc, 2);
      end
    end
    if (abort_after == 0) begin
      chk("completed", done_seen, 1);
      chk("n_blocks", got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) chk("block", got[i], exp[i]);
      want_cnt = (exp.size() > maxc) ? maxc : exp.size();
      chk("block_count", o_cnt, want_cnt);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'($urandom);
        drv_last  = 1'($urandom);
        drv_recv  = 1'b1;
        #1;
        chk("done_ready", o_rdy, 0);
        chk("done_valid", o_valid, 0);
        chk("done_hold", o_done, 1);
        chk("done_count", o_cnt, want_cnt);
      end
    end
    drv_valid = 1'b0;
    drv_recv  = 1'b0;
  endtask

  initial begin
    bq_t msg, rmsg;
    msg = str2q("Sponge + Present = Spongent");

    run_msg(0, msg, 0, 0);
    run_msg(1, msg, 0, 0);
    run_msg(1, str2q("AB"), 0, 0);
    run_msg(1, str2q("A"), 0, 0);
    run_msg(1, str2q("AB"), 1, 0);
    run_msg(0, str2q("xyz"), 1, 0);
    run_msg(1, msg, 0, 3);
    run_msg(1, str2q("AB"), 0, 0);
    run_msg(2, msg, 0, 0);

    for (int t = 0; t < 8; t++) begin
      rmsg.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) rmsg.push_back(8'($urandom));
      run_msg(int'($urandom_range(0, 2)), rmsg, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
